// File: rtl/pwm_multi.sv
`default_nettype none
// ============================================================================
// pwm_multi: N_CH PWM channels on one prescaled counter, shadowed period/compare
// (optional up/down counting with macro PWM_CENTER_ALIGN_EN).  Revision 1.0
// ============================================================================
module pwm_multi #(
  parameter int CTR_LEN   = 8,
  parameter int N_CH      = 4,
  parameter int PRESC_LEN = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [PRESC_LEN-1:0]      prescale,
  input  logic [CTR_LEN-1:0]        period,
  input  logic [N_CH*CTR_LEN-1:0]   compare,
  input  logic                      load,
  output logic [N_CH-1:0]           out,
  output logic                      period_end,
  output logic                      load_ack
);

  logic [PRESC_LEN-1:0]            presc_ctr;
  logic                            tick;
  logic [CTR_LEN-1:0]              ctr;
  logic [CTR_LEN-1:0]              ctr_next;
  logic                            wrap;
  logic [CTR_LEN-1:0]              period_active;
  logic [CTR_LEN-1:0]              period_pend;
  logic [N_CH-1:0][CTR_LEN-1:0]    cmp_active;
  logic [N_CH-1:0][CTR_LEN-1:0]    cmp_pend;
  logic                            pend_flag;
  logic [N_CH-1:0]                 out_next;

  // >= rather than == so lowering prescale mid-count never stalls for a full roll-over.
  assign tick = enable && (presc_ctr >= prescale);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_ctr <= '0;
    end else if (enable) begin
      presc_ctr <= tick ? '0 : presc_ctr + 1'b1;
    end
  end

`ifdef PWM_CENTER_ALIGN_EN
  // Direction names the next step: UP at ctr == 0, DOWN once ctr has reached period_active.
  typedef enum logic [0:0] {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_t;

  dir_t dir;
  dir_t dir_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir <= UP;
    end else begin
      dir <= dir_next;
    end
  end

  always_comb begin
    dir_next = dir;
    ctr_next = ctr;
    wrap     = 1'b0;
    if (tick) begin
      if (period_active == '0) begin
        ctr_next = '0;
        dir_next = UP;
        wrap     = 1'b1;
      end else begin
        unique case (dir)
          UP: begin
            ctr_next = ctr + 1'b1;
            if (ctr_next == period_active) begin
              dir_next = DOWN;
            end
          end
          DOWN: begin
            ctr_next = ctr - 1'b1;
            if (ctr_next == '0) begin
              dir_next = UP;
              wrap     = 1'b1;
            end
          end
          default: begin
            ctr_next = '0;
            dir_next = UP;
          end
        endcase
      end
    end
  end
`else
  always_comb begin
    ctr_next = ctr;
    wrap     = 1'b0;
    if (tick) begin
      if (ctr == period_active) begin
        ctr_next = '0;
        wrap     = 1'b1;
      end else begin
        ctr_next = ctr + 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctr <= '0;
    end else begin
      ctr <= ctr_next;
    end
  end

  // A load coinciding with a wrap wins over the flag clear, so it lands at the following wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_active <= '1;
      cmp_active    <= '0;
      period_pend   <= '0;
      cmp_pend      <= '0;
      pend_flag     <= 1'b0;
    end else begin
      if (wrap && pend_flag) begin
        period_active <= period_pend;
        cmp_active    <= cmp_pend;
      end
      if (load) begin
        period_pend <= period;
        cmp_pend    <= compare;
        pend_flag   <= 1'b1;
      end else if (wrap) begin
        pend_flag <= 1'b0;
      end
    end
  end

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_out
`ifdef PWM_CENTER_ALIGN_EN
      // >= on the way down makes the high time 2*compare ticks, symmetric about the wrap.
      assign out_next[i] = enable && ((dir == DOWN) ? (cmp_active[i] >= ctr)
                                                    : (cmp_active[i] > ctr));
`else
      assign out_next[i] = enable && (cmp_active[i] > ctr);
`endif
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out        <= '0;
      period_end <= 1'b0;
      load_ack   <= 1'b0;
    end else begin
      out        <= out_next;
      period_end <= wrap;
      load_ack   <= wrap && pend_flag;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi.sv
`default_nettype none
// ============================================================================
// tb_pwm_multi: per-period scoreboard for pwm_multi plus direct counter checks.
// Revision 1.0
// ============================================================================
module tb_pwm_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  prescale;
  logic [7:0]  period;
  logic [31:0] compare;
  logic        load;
  logic [3:0]  out;
  logic        period_end;
  logic        load_ack;

  pwm_multi #(.CTR_LEN(8), .N_CH(4), .PRESC_LEN(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .prescale   (prescale),
    .period     (period),
    .compare    (compare),
    .load       (load),
    .out        (out),
    .period_end (period_end),
    .load_ack   (load_ack)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    bit stats;
    int cyc;
    int hi[4];
    bit ack;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   strict   = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic push(input bit s, input int c, input int h0, input int h1,
                      input int h2, input int h3, input bit a);
    exp_t e;
    e.stats = s; e.cyc = c; e.ack = a;
    e.hi[0] = h0; e.hi[1] = h1; e.hi[2] = h2; e.hi[3] = h3;
    sb.push_back(e);
  endtask

  task automatic wait_pe(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_end && n < budget);
    if (!period_end) check("wait_period_end_timeout", 0, 1);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", sb.size(), 0);
  endtask

  // Monitor: accumulates each period window and scores it when period_end appears.
  initial begin
    int   win_cyc;
    int   win_hi[4];
    int   pe_idx;
    exp_t e;
    win_cyc = 0; pe_idx = 0;
    for (int i = 0; i < 4; i++) win_hi[i] = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        win_cyc = 0;
        for (int i = 0; i < 4; i++) win_hi[i] = 0;
      end else begin
        win_cyc++;
        for (int i = 0; i < 4; i++) win_hi[i] += int'(out[i]);
        if (load_ack) check("load_ack_with_period_end", int'(period_end), 1);
        if (period_end) begin
          if (strict || sb.size() != 0) check("period_end_expected", int'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            pe_idx++;
            check($sformatf("pe%0d_load_ack", pe_idx), int'(load_ack), int'(e.ack));
            if (e.stats) begin
              check($sformatf("pe%0d_period_len", pe_idx), win_cyc, e.cyc);
              for (int i = 0; i < 4; i++)
                check($sformatf("pe%0d_out%0d_high", pe_idx, i), win_hi[i], e.hi[i]);
            end
          end
          win_cyc = 0;
          for (int i = 0; i < 4; i++) win_hi[i] = 0;
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; load = 1'b0;
    prescale = '0; period = '0; compare = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_out", int'(out), 0);
    check("reset_period_end", int'(period_end), 0);
    check("reset_load_ack", int'(load_ack), 0);
    check("reset_ctr", int'(dut.ctr), 0);
    check("reset_period_active", int'(dut.period_active), 255);
    reset = 1'b0;
    repeat (2) @(negedge clk);

`ifdef PWM_CENTER_ALIGN_EN
    // Center-aligned: period 4, compare {5,4,0,2}
    prescale = 8'd0; period = 8'd4; compare = {8'd5, 8'd4, 8'd0, 8'd2};
    enable = 1'b1; load = 1'b1;
    push(0, 0, 0, 0, 0, 0, 1);
    repeat (3) push(1, 8, 4, 0, 8, 8, 0);
    @(negedge clk); load = 1'b0;
    wait_pe(1500);
    wait_pe(50);
    begin
      int seq[9] = '{0, 1, 2, 3, 4, 3, 2, 1, 0};
      for (int j = 0; j < 9; j++) begin
        if (j > 0) @(negedge clk);
        check($sformatf("center_ctr_step%0d", j), int'(dut.ctr), seq[j]);
      end
    end
    drain(100);
`else
    // Basic duty: period 9, compare {10,9,3,0}
    prescale = 8'd0; period = 8'd9; compare = {8'd10, 8'd9, 8'd3, 8'd0};
    enable = 1'b1; load = 1'b1;
    push(0, 0, 0, 0, 0, 0, 1);
    repeat (3) push(1, 10, 0, 3, 9, 10, 0);
    @(negedge clk); load = 1'b0;
    drain(3000);

    // Prescaler: prescale 3, period 4, compare {5,4,2,1}
    prescale = 8'd3; period = 8'd4; compare = {8'd5, 8'd4, 8'd2, 8'd1}; load = 1'b1;
    push(0, 0, 0, 0, 0, 0, 1);
    repeat (3) push(1, 20, 4, 8, 16, 20, 0);
    @(negedge clk); load = 1'b0;
    wait_pe(2000);
    wait_pe(100);
    for (int j = 0; j < 20; j++) begin
      if (j > 0) @(negedge clk);
      check($sformatf("presc_ctr_cycle%0d", j), int'(dut.ctr), j / 4);
    end
    drain(200);

    // Double load mid-period: old duty held until the wrap, last load wins
    prescale = 8'd0; period = 8'd9; compare = {8'd10, 8'd9, 8'd3, 8'd0}; load = 1'b1;
    push(0, 0, 0, 0, 0, 0, 1);
    push(1, 10, 0, 3, 9, 10, 0);
    push(1, 10, 0, 3, 9, 10, 1);
    push(1, 10, 0, 7, 9, 10, 0);
    @(negedge clk); load = 1'b0;
    wait_pe(200);
    wait_pe(50);
    repeat (3) @(negedge clk);
    compare = {8'd10, 8'd9, 8'd5, 8'd0}; load = 1'b1;
    @(negedge clk); load = 1'b0;
    repeat (2) @(negedge clk);
    compare = {8'd10, 8'd9, 8'd7, 8'd0}; load = 1'b1;
    @(negedge clk); load = 1'b0;

    // Load on the wrap cycle: applies one full period later
    wait_pe(50);
    wait_pe(50);
    push(1, 10, 0, 7, 9, 10, 0);
    push(1, 10, 0, 7, 9, 10, 1);
    push(1, 6, 0, 2, 5, 6, 0);
    repeat (9) @(negedge clk);
    check("ctr_before_wrap_load", int'(dut.ctr), 9);
    period = 8'd5; compare = {8'd6, 8'd5, 8'd2, 8'd0}; load = 1'b1;
    @(negedge clk); load = 1'b0;
    check("wrap_coincides_with_load", int'(period_end), 1);

    // Enable dropped for 15 cycles at ctr == 2
    wait_pe(50);
    wait_pe(50);
    push(1, 21, 0, 2, 5, 6, 0);
    push(1, 6, 0, 2, 5, 6, 0);
    repeat (2) @(negedge clk);
    enable = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 1 || k == 15) begin
        check($sformatf("disabled_out_k%0d", k), int'(out), 0);
        check($sformatf("disabled_ctr_k%0d", k), int'(dut.ctr), 2);
      end
    end
    enable = 1'b1;
    @(negedge clk);
    check("resume_ctr", int'(dut.ctr), 3);
    drain(100);
`endif

    // period_active = 0: wrap on every tick
    strict = 1'b0;
    period = 8'd0; compare = {8'd1, 8'd0, 8'd1, 8'd0}; load = 1'b1;
    push(0, 0, 0, 0, 0, 0, 1);
    repeat (4) push(1, 1, 0, 1, 0, 1, 0);
    @(negedge clk); load = 1'b0;
    drain(100);

    // Asynchronous reset between clock edges
    @(negedge clk);
    check("pre_reset_out", int'(out), 4'b1010);
    check("pre_reset_period_end", int'(period_end), 1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_out", int'(out), 0);
    check("async_reset_period_end", int'(period_end), 0);
    check("async_reset_load_ack", int'(load_ack), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_ctr", int'(dut.ctr), 1);
    check("post_reset_out", int'(out), 0);
    check("post_reset_period_end", int'(period_end), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
